// File: rtl/rv4028_pkg.sv
// Shared types and constants for the RV4028 instruction fetch front end.
// A prefetched halfword travels together with the ROM address it came from.
package rv4028_pkg;

  localparam int ROM_ADDR_W = 12;

  localparam logic [1:0] OPC_LEN32 = 2'b11;

  typedef struct packed {
    logic [15:0]           data;
    logic [ROM_ADDR_W-1:0] addr;
  } hw_entry_t;

endpackage

// File: rtl/rv4028_hw_fifo.sv
// Prefetch buffer of halfword entries; exposes the two oldest entries in parallel
// so a 32-bit instruction can be assembled and retired in a single cycle.
module rv4028_hw_fifo
  import rv4028_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [15:0]           push_data,
  input  logic [ROM_ADDR_W-1:0] push_addr,
  input  logic [1:0]            pop_n,
  output logic [15:0]           head0_data,
  output logic [ROM_ADDR_W-1:0] head0_addr,
  output logic [15:0]           head1_data,
  output logic [ROM_ADDR_W-1:0] head1_addr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  hw_entry_t       mem [DEPTH];
  hw_entry_t       entry0;
  hw_entry_t       entry1;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     cnt;

  assign entry0     = mem[rd_ptr];
  assign entry1     = mem[rd_ptr + 1'b1];
  assign head0_data = entry0.data;
  assign head0_addr = entry0.addr;
  assign head1_data = entry1.data;
  assign head1_addr = entry1.addr;
  assign count      = cnt;

  // Pointers wrap naturally because the depth is a power of two; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr + PW'(pop_n);
      cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{data: push_data, addr: push_addr};
  end

endmodule

// File: rtl/rv4028_rom_fetch.sv
// Fetch front end between the RV4028 core and the 16-bit program ROM: issues
// sequential halfword reads, buffers them and hands whole RVC/RV32 instructions to the core.
module rv4028_rom_fetch
  import rv4028_pkg::*;
#(
  parameter logic [ROM_ADDR_W-1:0] RESET_PC   = 12'h000,
  parameter int                    ROM_WORDS  = 3072,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ren,
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [11:0] instr_pc,
  output logic        instr_is_c
);

  localparam int                    CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ROM_ADDR_W-1:0] LAST_HW = ROM_ADDR_W'(ROM_WORDS - 1);

  logic [11:0]   fetch_addr;
  logic [11:0]   resp_addr;
  logic          inflight;
  logic          discard;
  logic          issue;
  logic          push;
  logic [1:0]    pop_n;
  logic [CW-1:0] count;
  logic [15:0]   head0_data;
  logic [11:0]   head0_addr;
  logic [15:0]   head1_data;
  logic [11:0]   head1_addr;
  logic          head_is32;
  logic [31:0]   cur_data;
  logic [31:0]   held_data;
  logic [11:0]   held_pc;
  logic          held_c;

  rv4028_hw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  (rom_data),
    .push_addr  (resp_addr),
    .pop_n      (pop_n),
    .head0_data (head0_data),
    .head0_addr (head0_addr),
    .head1_data (head1_data),
    .head1_addr (head1_addr),
    .count      (count)
  );

  // Space is judged on the registered count plus the read already in flight,
  // so a slot freed by this cycle's pop only becomes usable next cycle.
  assign issue     = !rst && !redirect &&
                     (({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(FIFO_DEPTH));
  assign rom_ren   = issue;
  assign rom_addr  = fetch_addr;
  assign push      = inflight && !discard;

  assign head_is32   = (head0_data[1:0] == OPC_LEN32);
  assign instr_valid = head_is32 ? (count >= CW'(2)) : (count >= CW'(1));
  assign pop_n       = (instr_valid && instr_ready) ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
  assign cur_data    = head_is32 ? {head1_data, head0_data} : {16'h0000, head0_data};

  assign instr_data = instr_valid ? cur_data   : held_data;
  assign instr_pc   = instr_valid ? head0_addr : held_pc;
  assign instr_is_c = instr_valid ? !head_is32 : held_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= RESET_PC;
      resp_addr  <= RESET_PC;
      inflight   <= 1'b0;
      discard    <= 1'b0;
    end else begin
      inflight <= issue;
      discard  <= redirect && inflight;
      if (redirect) begin
        fetch_addr <= redirect_pc;
      end else if (issue) begin
        fetch_addr <= (fetch_addr == LAST_HW) ? '0 : fetch_addr + 12'd1;
        resp_addr  <= fetch_addr;
      end
    end
  end

  // Last presented instruction stays on the outputs while nothing complete is buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_data <= '0;
      held_pc   <= RESET_PC;
      held_c    <= 1'b0;
    end else if (instr_valid) begin
      held_data <= cur_data;
      held_pc   <= head0_addr;
      held_c    <= !head_is32;
    end
  end

endmodule

// File: tb/tb_rv4028_rom_fetch.sv
// Directed and randomized bench for rv4028_rom_fetch with a behavioural ROM and an
// instruction-stream reference model driven purely by ROM contents and redirect targets.
module tb_rv4028_rom_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ren;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [11:0] instr_pc;
  logic        instr_is_c;

  logic [15:0] romMem [3072];
  logic [11:0] expPc = 12'h000;
  int          checks = 0;
  int          errors = 0;
  int          hsCount = 0;

  rv4028_rom_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ren     (rom_ren),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_is_c  (instr_is_c)
  );

  always #5 clk = ~clk;

  // One-cycle ROM; idle cycles return junk so stray pushes corrupt the stream visibly.
  always @(posedge clk) begin
    if (rom_ren) rom_data <= (rom_addr < 12'd3072) ? romMem[rom_addr] : 16'hdead;
    else         rom_data <= 16'($urandom);
  end

  function automatic logic [11:0] nextPc(input logic [11:0] p);
    return (p == 12'd3071) ? 12'd0 : p + 12'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [11:0] rpc, input logic rdy);
    redirect    = r;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
  endtask

  // Reference model: the instruction stream is the ROM read sequentially from expPc.
  task automatic modelCheck();
    logic [15:0] hw0;
    logic [11:0] p1;
    logic        is32;
    logic [31:0] exp;
    if (!rst && instr_valid && instr_ready) begin
      hw0  = romMem[expPc];
      p1   = nextPc(expPc);
      is32 = (hw0[1:0] == 2'b11);
      exp  = is32 ? {romMem[p1], hw0} : {16'h0000, hw0};
      checkOutput("hs_data", instr_data, exp);
      checkOutput("hs_pc", {20'h0, instr_pc}, {20'h0, expPc});
      checkOutput("hs_is_c", {31'h0, instr_is_c}, {31'h0, !is32});
      expPc = is32 ? nextPc(p1) : p1;
      hsCount++;
    end
    if (!rst && redirect) expPc = redirect_pc;
  endtask

  task automatic tick();
    @(negedge clk);
    modelCheck();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    #1;
    rst         = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    expPc       = 12'h000;
    #1;
    checkOutput("rst_rom_ren", {31'h0, rom_ren}, 32'h0);
    checkOutput("rst_rom_addr", {20'h0, rom_addr}, 32'h0);
    checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_data", instr_data, 32'h0);
    checkOutput("rst_pc", {20'h0, instr_pc}, 32'h0);
    checkOutput("rst_is_c", {31'h0, instr_is_c}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      applyStimulus(1'b0, 12'h000, 1'b1);
      if (instr_valid) begin
        n = i;
        return;
      end
      tick();
    end
    checkOutput(tag, 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    int issues;
    int hsStart;

    for (int i = 0; i < 3072; i++) romMem[i] = 16'($urandom);
    romMem[0] = 16'h4501;
    romMem[1] = 16'h4582;
    romMem[2] = 16'h4601;
    romMem[3] = 16'h4681;
    romMem[4] = 16'h0093;
    romMem[5] = 16'h0010;
    romMem[6] = 16'h0001;

    // Compressed start-up latency and ordering.
    applyReset();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("c1_rom_ren", {31'h0, rom_ren}, 32'h1);
    checkOutput("c1_rom_addr", {20'h0, rom_addr}, 32'h0);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("c2_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("c3_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("c3_data", instr_data, 32'h00004501);
    checkOutput("c3_pc", {20'h0, instr_pc}, 32'h0);
    checkOutput("c3_is_c", {31'h0, instr_is_c}, 32'h1);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("c4_data", instr_data, 32'h00004582);
    checkOutput("c4_pc", {20'h0, instr_pc}, 32'h1);
    tick();

    // 32-bit instruction reached through a redirect to address 4.
    applyStimulus(1'b1, 12'd4, 1'b1);
    checkOutput("r32_rom_ren_off", {31'h0, rom_ren}, 32'h0);
    tick();
    waitValid("r32_timeout", 8, n);
    checkOutput("r32_latency", n, 32'd4);
    checkOutput("r32_data", instr_data, 32'h00100093);
    checkOutput("r32_pc", {20'h0, instr_pc}, 32'h4);
    checkOutput("r32_is_c", {31'h0, instr_is_c}, 32'h0);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("r32_next_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("r32_next_pc", {20'h0, instr_pc}, 32'h6);
    tick();

    // Consumer stalled: buffer fills with exactly four halfwords, none lost.
    applyReset();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 12'h000, 1'b0);
      if (rom_ren) issues++;
      if (i == 9) checkOutput("full_rom_ren_off", {31'h0, rom_ren}, 32'h0);
      tick();
    end
    checkOutput("full_issue_count", issues, 32'd4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 12'h000, 1'b1);
      checkOutput("full_drain_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("full_drain_pc", {20'h0, instr_pc}, k);
      tick();
    end

    // Redirect while the read of address 3 is in flight.
    applyReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 12'h000, 1'b0);
      if (i == 4) begin
        checkOutput("rd_issue3_ren", {31'h0, rom_ren}, 32'h1);
        checkOutput("rd_issue3_addr", {20'h0, rom_addr}, 32'h3);
      end
      tick();
    end
    applyStimulus(1'b1, 12'h100, 1'b0);
    checkOutput("rd_rom_ren_off", {31'h0, rom_ren}, 32'h0);
    tick();
    waitValid("rd_timeout", 8, n);
    checkOutput("rd_first_pc", {20'h0, instr_pc}, 32'h100);
    tick();

    // Reset pulse mid-stream with three halfwords buffered and one read in flight.
    applyReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 12'h000, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 12'h000, 1'b0);
    checkOutput("mid_pre_valid", {31'h0, instr_valid}, 32'h1);
    rst   = 1'b1;
    expPc = 12'h000;
    #1;
    checkOutput("mid_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("mid_rom_addr", {20'h0, rom_addr}, 32'h0);
    checkOutput("mid_rom_ren", {31'h0, rom_ren}, 32'h0);
    tick();
    rst = 1'b0;
    waitValid("mid_timeout", 8, n);
    checkOutput("mid_first_pc", {20'h0, instr_pc}, 32'h0);
    checkOutput("mid_first_data", instr_data, {16'h0000, romMem[0]});
    tick();

    // 32-bit instruction straddling the end of the ROM.
    romMem[3071] = 16'h0013;
    romMem[0]    = 16'h0000;
    applyStimulus(1'b1, 12'd3071, 1'b1);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("wrap_ren", {31'h0, rom_ren}, 32'h1);
    checkOutput("wrap_addr_last", {20'h0, rom_addr}, 32'd3071);
    tick();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("wrap_addr_zero", {20'h0, rom_addr}, 32'h0);
    tick();
    waitValid("wrap_timeout", 8, n);
    checkOutput("wrap_latency", n, 32'd2);
    checkOutput("wrap_data", instr_data, 32'h00000013);
    checkOutput("wrap_pc", {20'h0, instr_pc}, 32'd3071);
    checkOutput("wrap_is_c", {31'h0, instr_is_c}, 32'h0);
    tick();

    // Random ROM traffic with random back-pressure and redirects.
    hsStart = hsCount;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 15) == 0,
                    ($urandom_range(0, 3) == 0) ? 12'($urandom_range(3064, 3071))
                                                : 12'($urandom_range(0, 3071)),
                    $urandom_range(0, 3) != 0);
      tick();
    end
    checkOutput("rand_throughput", {31'h0, (hsCount - hsStart) >= 200}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
